// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the multicycle MIPS datapath.
// Owns the PC. On a fetch request from the control unit it reads one 32-bit word
// over a request/ready memory handshake. It then presents the word to the instruction
// register with a one-cycle ir_write strobe and advances the PC.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   When this macro is defined, a fetch from an address that is not word aligned
//   never reaches memory. Instead it raises a one-cycle fetch_fault pulse.
//   When it is undefined, fetch_fault is tied to 0.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   fetch_req          request one fetch (sampled only while idle)
//   pc_load, pc_in     PC redirect; applied when idle, deferred while a fetch is in flight
//   mem_read           memory read request, held until mem_ready
//   mem_address        word address of the read
//   mem_ready          memory read data valid / request accepted
//   mem_rdata          memory read data
//   ir_write           one-cycle load strobe to the instruction register
//   ir_data            last fetched instruction word
//   pc_out             current PC
//   busy               high whenever the unit is not idle
//   fetch_done         one-cycle pulse coincident with ir_write
//   fetch_fault        one-cycle misaligned-fetch pulse
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        pc_load,
  input  logic [31:0] pc_in,
  output logic        mem_read,
  output logic [31:0] mem_address,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        ir_write,
  output logic [31:0] ir_data,
  output logic [31:0] pc_out,
  output logic        busy,
  output logic        fetch_done,
  output logic        fetch_fault
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {StIdle, StIssue, StWriteback, StFault} state_e;
`else
  typedef enum logic [1:0] {StIdle, StIssue, StWriteback} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        read_q, read_d;
  logic [31:0] ir_data_q, ir_data_d;
  logic        ir_write_q, ir_write_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] issue_addr;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fault_q, fault_d;
`endif

  // A redirect arriving together with a fetch request takes effect for that fetch.
  assign issue_addr = pc_load ? pc_in : pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    read_d       = read_q;
    ir_data_d    = ir_data_q;
    ir_write_d   = 1'b0;
    done_d       = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d      = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (fetch_req) begin
          pc_d = issue_addr;
`ifdef FETCH_ALIGN_CHECK_EN
          if (issue_addr[1:0] != 2'b00) begin
            state_d = StFault;
            fault_d = 1'b1;
          end else
`endif
          begin
            state_d = StIssue;
            read_d  = 1'b1;
            addr_d  = issue_addr;
          end
        end else if (pc_load) begin
          pc_d = pc_in;
        end
      end
      StIssue: begin
        // A redirect cannot cancel the fetch in flight. It is held until writeback.
        if (pc_load) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = pc_in;
        end
        if (mem_ready) begin
          ir_data_d  = mem_rdata;
          read_d     = 1'b0;
          ir_write_d = 1'b1;
          done_d     = 1'b1;
          state_d    = StWriteback;
        end
      end
      StWriteback: begin
        state_d      = StIdle;
        pend_valid_d = 1'b0;
        if (pc_load) begin
          pc_d = pc_in;  // the newest redirect wins over an older pending one
        end else if (pend_valid_q) begin
          pc_d = pend_pc_q;
        end else begin
          pc_d = pc_q + PC_STEP;
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      StFault: begin
        state_d = StIdle;
        if (pc_load) pc_d = pc_in;
      end
`endif
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      addr_q       <= 32'h0;
      read_q       <= 1'b0;
      ir_data_q    <= 32'h0;
      ir_write_q   <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      read_q       <= read_d;
      ir_data_q    <= ir_data_d;
      ir_write_q   <= ir_write_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q      <= fault_d;
`endif
    end
  end

  assign mem_read    = read_q;
  assign mem_address = addr_q;
  assign ir_write    = ir_write_q;
  assign ir_data     = ir_data_q;
  assign pc_out      = pc_q;
  assign busy        = busy_q;
  assign fetch_done  = done_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. Inputs are driven and outputs sampled on the
// falling edge. The expected PC and IR contents come from a transaction-level model:
// the issue address, then either the last redirect seen or the issue address plus the step.
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  logic        clock = 1'b0;
  logic        reset, fetch_req, pc_load, mem_ready;
  logic        mem_read, ir_write, busy, fetch_done, fetch_fault;
  logic [31:0] pc_in, mem_address, mem_rdata, ir_data, pc_out;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_pc;
  logic [31:0] model_ir;

  instr_fetch_unit #(
    .RESET_PC(RESET_PC),
    .PC_STEP (PC_STEP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .pc_load    (pc_load),
    .pc_in      (pc_in),
    .mem_read   (mem_read),
    .mem_address(mem_address),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .ir_write   (ir_write),
    .ir_data    (ir_data),
    .pc_out     (pc_out),
    .busy       (busy),
    .fetch_done (fetch_done),
    .fetch_fault(fetch_fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One fetch from IDLE. wt is the number of wait cycles before mem_ready. A redirect
  // is driven in ISSUE cycle redir_at; wt+1 means the WRITEBACK cycle, and -1 means none.
  task automatic do_fetch(input logic load, input logic [31:0] target, input int wt,
                          input logic [31:0] rdata, input int redir_at,
                          input logic [31:0] redir_pc, input logic extra_req);
    logic [31:0] a;
    logic [31:0] exp_pc;
    a      = load ? target : model_pc;
    exp_pc = a + PC_STEP;
    check("idle_busy", {31'b0, busy}, 32'd0);
    fetch_req = 1'b1;
    pc_load   = load;
    pc_in     = target;
    mem_ready = 1'b0;
    @(negedge clock);
    fetch_req = extra_req;  // a request while busy must be ignored
    for (int w = 0; w <= wt; w++) begin
      check("issue_read", {31'b0, mem_read}, 32'd1);
      check("issue_addr", mem_address, a);
      check("issue_no_irw", {31'b0, ir_write}, 32'd0);
      check("issue_busy", {31'b0, busy}, 32'd1);
      if (w == redir_at) begin
        pc_load = 1'b1;
        pc_in   = redir_pc;
        exp_pc  = redir_pc;
      end else begin
        pc_load = 1'b0;
        pc_in   = $urandom;
      end
      mem_ready = (w == wt);
      mem_rdata = (w == wt) ? rdata : $urandom;
      @(negedge clock);
      fetch_req = 1'b0;
    end
    check("wb_irw", {31'b0, ir_write}, 32'd1);
    check("wb_done", {31'b0, fetch_done}, 32'd1);
    check("wb_ir_data", ir_data, rdata);
    check("wb_read_low", {31'b0, mem_read}, 32'd0);
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    if (redir_at == wt + 1) begin
      pc_load = 1'b1;
      pc_in   = redir_pc;
      exp_pc  = redir_pc;
    end else begin
      pc_load = 1'b0;
    end
    @(negedge clock);
    pc_load = 1'b0;
    check("post_pc", pc_out, exp_pc);
    check("post_irw", {31'b0, ir_write}, 32'd0);
    check("post_read", {31'b0, mem_read}, 32'd0);
    check("post_busy", {31'b0, busy}, 32'd0);
    check("post_ir_hold", ir_data, rdata);
    model_pc = exp_pc;
    model_ir = rdata;
  endtask

  initial begin
    reset     = 1'b1;
    fetch_req = 1'b0;
    pc_load   = 1'b0;
    pc_in     = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_pc = RESET_PC;
    model_ir = 32'h0;
    check("rst_pc", pc_out, RESET_PC);
    check("rst_read", {31'b0, mem_read}, 32'd0);
    check("rst_addr", mem_address, 32'h0);
    check("rst_irw", {31'b0, ir_write}, 32'd0);
    check("rst_ir", ir_data, 32'h0);
    check("rst_done", {31'b0, fetch_done}, 32'd0);
    check("rst_fault", {31'b0, fetch_fault}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);

    // Immediate ready, then a five-cycle memory wait.
    do_fetch(1'b0, 32'h0, 0, 32'h8C22_0004, -1, 32'h0, 1'b0);
    do_fetch(1'b0, 32'h0, 5, 32'h0123_4567, -1, 32'h0, 1'b1);
    // A redirect during ISSUE replaces the increment.
    do_fetch(1'b0, 32'h0, 2, 32'hAC41_0008, 1, 32'h0040_0100, 1'b0);
    // Wrap-around of the PC.
    do_fetch(1'b1, 32'hFFFF_FFFC, 1, 32'h2008_0001, -1, 32'h0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      int wt;
      int ra;
      if ($urandom_range(0, 4) == 0) begin
        pc_load = 1'b1;
        pc_in   = $urandom & 32'hFFFF_FFFC;
        model_pc = pc_in;
        @(negedge clock);
        pc_load = 1'b0;
        check("idle_load_pc", pc_out, model_pc);
        check("idle_load_busy", {31'b0, busy}, 32'd0);
      end
      wt = $urandom_range(0, 3);
      ra = $urandom_range(0, wt + 3);
      if (ra > wt + 1) ra = -1;
      do_fetch(($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFC, wt, $urandom, ra,
               $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
    end

    // Reset during the second ISSUE cycle aborts the fetch.
    fetch_req = 1'b1;
    mem_ready = 1'b0;
    @(negedge clock);
    check("abort_issue", {31'b0, mem_read}, 32'd1);
    @(negedge clock);
    fetch_req = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_pc = RESET_PC;
    model_ir = 32'h0;
    check("abort_read", {31'b0, mem_read}, 32'd0);
    check("abort_irw", {31'b0, ir_write}, 32'd0);
    check("abort_pc", pc_out, model_pc);
    check("abort_busy", {31'b0, busy}, 32'd0);
    @(negedge clock);
    check("abort_no_refetch", {31'b0, mem_read}, 32'd0);
    check("abort_no_late_irw", {31'b0, ir_write}, 32'd0);
    check("abort_ir", ir_data, model_ir);

`ifdef FETCH_ALIGN_CHECK_EN
    fetch_req = 1'b1;
    pc_load   = 1'b1;
    pc_in     = 32'h0000_0006;
    @(negedge clock);
    fetch_req = 1'b0;
    pc_load   = 1'b0;
    check("fault_pulse", {31'b0, fetch_fault}, 32'd1);
    check("fault_no_read", {31'b0, mem_read}, 32'd0);
    check("fault_busy", {31'b0, busy}, 32'd1);
    @(negedge clock);
    check("fault_end", {31'b0, fetch_fault}, 32'd0);
    check("fault_no_irw", {31'b0, ir_write}, 32'd0);
    check("fault_no_read2", {31'b0, mem_read}, 32'd0);
    check("fault_pc", pc_out, 32'h0000_0006);
    check("fault_idle", {31'b0, busy}, 32'd0);
`else
    do_fetch(1'b1, 32'h0000_0006, 0, 32'h1234_5678, -1, 32'h0, 1'b0);
    check("no_fault", {31'b0, fetch_fault}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
